// File: rtl/systolic_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : systolic_drain                                               |
// | Description : Captures skewed per-PE results of an N x N systolic array    |
// |               into a capture bank, hands complete tiles to a drain bank   |
// |               and streams them word by word into an M x M row-major       |
// |               result memory with a valid/ready write handshake.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module systolic_drain #(
    parameter int D_W_ACC = 16,
    parameter int N       = 3,
    parameter int M       = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N*N*D_W_ACC-1:0]    D,
    input  logic [N*N-1:0]            valid_D,
    input  logic                      wr_ready,
    output logic                      wr_en,
    output logic [$clog2(M*M)-1:0]    wr_addr,
    output logic [D_W_ACC-1:0]        wr_data,
    output logic                      tile_done,
    output logic                      done,
    output logic                      overflow
);

    localparam int c_NW    = N * N;
    localparam int c_AW    = $clog2(M * M);
    localparam int c_TPR   = M / N;
    localparam int c_TILES = c_TPR * c_TPR;
    localparam int c_CW    = (N > 1) ? $clog2(N) : 1;
    localparam int c_IW    = (c_NW > 1) ? $clog2(c_NW) : 1;
    localparam int c_TW    = (c_TPR > 1) ? $clog2(c_TPR) : 1;
    localparam int c_TCW   = $clog2(c_TILES + 1);

    localparam logic [c_CW-1:0]  c_XMAX  = c_CW'(N - 1);
    localparam logic [c_TW-1:0]  c_TMAX  = c_TW'(c_TPR - 1);
    localparam logic [c_TCW-1:0] c_TLAST = c_TCW'(c_TILES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Capture bank, drain bank and drain bookkeeping
    logic [D_W_ACC-1:0] r_cap   [c_NW];
    logic [D_W_ACC-1:0] r_drain [c_NW];
    logic [c_NW-1:0]    r_flag;
    state_t             r_state;
    logic [c_CW-1:0]    r_x;
    logic [c_CW-1:0]    r_y;
    logic [c_IW-1:0]    r_idx;
    logic [c_TW-1:0]    r_trow;
    logic [c_TW-1:0]    r_tcol;
    logic [c_TCW-1:0]   r_tile;
    logic               r_wr_en;
    logic [c_AW-1:0]    r_wr_addr;
    logic [D_W_ACC-1:0] r_wr_data;
    logic               r_tile_done;
    logic               r_done;
    logic               r_overflow;

    logic [D_W_ACC-1:0] w_d   [c_NW];
    logic [D_W_ACC-1:0] w_eff [c_NW];
    logic [c_NW-1:0]    w_vld;
    logic [c_NW-1:0]    w_cap_we;
    logic               w_accept;
    logic               w_last;
    logic               w_xfer;
    logic               w_ovf;
    logic [c_TW-1:0]    w_ntrow;
    logic [c_TW-1:0]    w_ntcol;
    logic [c_TW-1:0]    w_xrow;
    logic [c_TW-1:0]    w_xcol;
    logic [c_CW-1:0]    w_nx;
    logic [c_CW-1:0]    w_ny;
    logic [c_IW-1:0]    w_nidx;

    // Row-major result address, evaluated at integer width before narrowing
    function automatic logic [c_AW-1:0] f_addr(
        input logic [c_TW-1:0] trow,
        input logic [c_TW-1:0] tcol,
        input logic [c_CW-1:0] x,
        input logic [c_CW-1:0] y
    );
        int v;
        v = ((int'(trow) * N) + int'(x)) * M + int'(tcol) * N + int'(y);
        return v[c_AW-1:0];
    endfunction

    // Handshake, bank-transfer decision and next-word/next-tile arithmetic
    always_comb begin
        w_vld = (rst || r_done) ? '0 : valid_D;
        for (int k = 0; k < c_NW; k++) begin
            w_d[k]   = D[k*D_W_ACC +: D_W_ACC];
            // A word arriving in the transfer cycle for an empty slot goes
            // straight to the drain bank; a held word always wins.
            w_eff[k] = r_flag[k] ? r_cap[k] : w_d[k];
        end
        w_accept = (r_state == ST_DRAIN) && wr_ready;
        w_last   = w_accept && (r_x == c_XMAX) && (r_y == c_XMAX);
        // Transfer needs a free drain bank (idle, or emptying this cycle on a
        // tile that is not the final one) and a complete capture bank.
        w_xfer   = !rst && !r_done && (&(r_flag | w_vld)) &&
                   ((r_state == ST_IDLE) || (w_last && (r_tile != c_TLAST)));
        // On transfer only re-pulsed slots stay captured; otherwise empty
        // slots accept new data.
        w_cap_we = w_xfer ? (r_flag & w_vld) : (~r_flag & w_vld);
        w_ovf    = r_done ? (|valid_D) : (!w_xfer && (|(r_flag & w_vld)));

        w_ntcol  = (r_tcol == c_TMAX) ? '0 : r_tcol + 1'b1;
        w_ntrow  = (r_tcol == c_TMAX) ? r_trow + 1'b1 : r_trow;
        w_xrow   = (r_state == ST_DRAIN) ? w_ntrow : r_trow;
        w_xcol   = (r_state == ST_DRAIN) ? w_ntcol : r_tcol;
        w_ny     = (r_y == c_XMAX) ? '0 : r_y + 1'b1;
        w_nx     = (r_y == c_XMAX) ? r_x + 1'b1 : r_x;
        w_nidx   = r_idx + 1'b1;
    end

    // Capture flags, drain FSM, tile tracking and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag      <= '0;
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_idx       <= '0;
            r_trow      <= '0;
            r_tcol      <= '0;
            r_tile      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_tile_done <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_tile_done <= w_last;
            r_flag      <= w_xfer ? (r_flag & w_vld) : (r_flag | w_vld);
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_last) begin
                r_tile <= r_tile + 1'b1;
                r_trow <= w_ntrow;
                r_tcol <= w_ntcol;
                if (r_tile == c_TLAST) begin
                    r_done <= 1'b1;
                end
            end
            if (w_xfer) begin
                r_state   <= ST_DRAIN;
                r_wr_en   <= 1'b1;
                r_x       <= '0;
                r_y       <= '0;
                r_idx     <= '0;
                r_wr_addr <= f_addr(w_xrow, w_xcol, '0, '0);
                r_wr_data <= w_eff[0];
            end else if (w_last) begin
                r_state <= ST_IDLE;
                r_wr_en <= 1'b0;
            end else if (w_accept) begin
                r_x       <= w_nx;
                r_y       <= w_ny;
                r_idx     <= w_nidx;
                r_wr_addr <= f_addr(r_trow, r_tcol, w_nx, w_ny);
                r_wr_data <= r_drain[w_nidx];
            end
        end
    end

    // Data storage of both banks; validity lives in the flags and the FSM
    always_ff @(posedge clk) begin
        for (int k = 0; k < c_NW; k++) begin
            if (w_cap_we[k]) begin
                r_cap[k] <= w_d[k];
            end
            if (w_xfer) begin
                r_drain[k] <= w_eff[k];
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign tile_done = r_tile_done;
    assign done      = r_done;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_systolic_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_systolic_drain                                            |
// | Description : Self-checking bench for systolic_drain: table-driven tile,   |
// |               directed corner sequences and randomized tiles against a    |
// |               tile/address reference model.                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_systolic_drain;

    localparam int D_W_ACC = 16;
    localparam int N       = 3;
    localparam int M       = 6;
    localparam int NW      = N * N;
    localparam int AW      = $clog2(M * M);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NW*D_W_ACC-1:0]  D = '0;
    logic [NW-1:0]          valid_D = '0;
    logic                   wr_ready = 1'b0;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [D_W_ACC-1:0]     wr_data;
    logic                   tile_done;
    logic                   done;
    logic                   overflow;

    systolic_drain #(.D_W_ACC(D_W_ACC), .N(N), .M(M)) dut (
        .clk(clk), .rst(rst), .D(D), .valid_D(valid_D), .wr_ready(wr_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tile_done(tile_done), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; int cyc; } acc_t;
    typedef struct { int x; int y; int d; int exp_addr; int exp_data; } vec_t;

    acc_t acc_q[$];
    int   cyc = 0;
    int   td_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   rnd_rdy = 1'b0;
    int   tdat[4][NW];

    logic              p_en = 1'b0, p_rdy = 1'b0, p_rst = 1'b1;
    logic [AW-1:0]     p_addr = '0;
    logic [D_W_ACC-1:0] p_data = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Cycle counter used to time-stamp accepted writes
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: logs accepted writes, counts tile_done, checks hold under stall
    always @(negedge clk) begin
        if (wr_en && wr_ready && !rst)
            acc_q.push_back('{addr: int'(wr_addr), data: int'(wr_data), cyc: cyc});
        if (tile_done && !rst) td_cnt++;
        if (p_en && !p_rdy && !p_rst) begin
            chk("hold_en", 32'(wr_en), 32'd1);
            chk("hold_addr", 32'(wr_addr), 32'(p_addr));
            chk("hold_data", 32'(wr_data), 32'(p_data));
        end
        p_en   <= wr_en;
        p_rdy  <= wr_ready;
        p_rst  <= rst;
        p_addr <= wr_addr;
        p_data <= wr_data;
    end

    // Absolute time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        if (rnd_rdy) wr_ready = ($urandom % 4) != 0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(int k, int val);
        D[k*D_W_ACC +: D_W_ACC] = D_W_ACC'(val);
    endtask

    function automatic int exp_addr(int t, int x, int y);
        int tpr = M / N;
        return ((t / tpr) * N + x) * M + (t % tpr) * N + y;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        valid_D = '0;
        tick();
        tick();
        rst = 1'b0;
        acc_q.delete();
        td_cnt = 0;
    endtask

    task automatic wait_acc(int n, int budget);
        int b = 0;
        while (acc_q.size() < n && b < budget) begin
            tick();
            b++;
        end
        n_vec++;
        if (acc_q.size() < n) begin
            n_err++;
            $display("FAIL wait_acc: got %0d accepts expected %0d", acc_q.size(), n);
        end
    endtask

    task automatic rand_tiles(int ntiles);
        for (int t = 0; t < ntiles; t++)
            for (int k = 0; k < NW; k++) tdat[t][k] = int'($urandom_range(0, 65535));
    endtask

    task automatic send_all(int t);
        for (int k = 0; k < NW; k++) set_word(k, tdat[t][k]);
        valid_D = '1;
        tick();
        valid_D = '0;
    endtask

    task automatic compare_stream(string tag, int ntiles);
        for (int i = 0; i < ntiles * NW; i++) begin
            if (i < acc_q.size()) begin
                chk($sformatf("%s_addr[%0d]", tag, i), 32'(acc_q[i].addr),
                    32'(exp_addr(i / NW, (i % NW) / N, (i % NW) % N)));
                chk($sformatf("%s_data[%0d]", tag, i), 32'(acc_q[i].data),
                    32'(tdat[i / NW][i % NW]));
            end
        end
    endtask

    initial begin
        vec_t tbl[NW];
        int   last_cyc;
        int   b;
        logic [NW-1:0] rem, sel;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_tile_done", 32'(tile_done), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overflow", 32'(overflow), 0);

        // ---------------- table-driven skewed tile 0 ----------------
        tbl[0] = '{0, 0,  0,  0,  0};
        tbl[1] = '{0, 1,  1,  1,  1};
        tbl[2] = '{0, 2,  2,  2,  2};
        tbl[3] = '{1, 0, 10,  6, 10};
        tbl[4] = '{1, 1, 11,  7, 11};
        tbl[5] = '{1, 2, 12,  8, 12};
        tbl[6] = '{2, 0, 20, 12, 20};
        tbl[7] = '{2, 1, 21, 13, 21};
        tbl[8] = '{2, 2, 22, 14, 22};
        wr_ready = 1'b1;
        last_cyc = 0;
        for (int c = 0; c <= 2 * (N - 1); c++) begin
            valid_D = '0;
            for (int i = 0; i < NW; i++) begin
                if (tbl[i].x + tbl[i].y == c) begin
                    valid_D[tbl[i].x * N + tbl[i].y] = 1'b1;
                    set_word(tbl[i].x * N + tbl[i].y, tbl[i].d);
                end
            end
            last_cyc = cyc;
            tick();
        end
        valid_D = '0;
        wait_acc(NW, 40);
        for (int i = 0; i < NW; i++) begin
            if (i < acc_q.size()) begin
                chk($sformatf("tbl_addr[%0d]", i), 32'(acc_q[i].addr), 32'(tbl[i].exp_addr));
                chk($sformatf("tbl_data[%0d]", i), 32'(acc_q[i].data), 32'(tbl[i].exp_data));
                chk($sformatf("tbl_cyc[%0d]", i), 32'(acc_q[i].cyc), 32'(last_cyc + 1 + i));
            end
        end
        tick();
        tick();
        chk("tbl_tile_done_cnt", 32'(td_cnt), 1);
        chk("tbl_extra_writes", 32'(acc_q.size()), 9);

        // ---------------- wr_ready toggling during drain ----------------
        do_reset();
        rand_tiles(1);
        wr_ready = 1'b1;
        send_all(0);
        b = 0;
        while (acc_q.size() < NW && b < 60) begin
            wr_ready = (b % 2) == 0;
            tick();
            b++;
        end
        wr_ready = 1'b1;
        tick();
        tick();
        chk("tog_accepts", 32'(acc_q.size()), 9);
        compare_stream("tog", 1);

        // ---------------- capture while stalled, then overflow ----------------
        do_reset();
        rand_tiles(2);
        wr_ready = 1'b0;
        send_all(0);
        send_all(1);
        tick();
        tick();
        chk("stall_no_ovf", 32'(overflow), 0);
        set_word(0, tdat[1][0] ^ 16'h5A5A);
        valid_D = 9'h001;
        tick();
        valid_D = '0;
        tick();
        chk("stall_ovf", 32'(overflow), 1);
        chk("stall_no_write", 32'(acc_q.size()), 0);
        wr_ready = 1'b1;
        wait_acc(2 * NW, 60);
        compare_stream("stall", 2);

        // ---------------- reset mid-drain ----------------
        do_reset();
        rand_tiles(1);
        wr_ready = 1'b1;
        send_all(0);
        valid_D = 9'h001;
        tick();
        tick();
        valid_D = '0;
        wait_acc(4, 20);
        chk("mid_ovf_before", 32'(overflow), 1);
        rst = 1'b1;
        valid_D = '1;
        tick();
        rst = 1'b0;
        valid_D = '0;
        chk("mid_wr_en", 32'(wr_en), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_ovf", 32'(overflow), 0);
        tick();
        tick();
        tick();
        chk("mid_no_writes", 32'(acc_q.size()), 4);
        chk("mid_wr_en_idle", 32'(wr_en), 0);
        acc_q.delete();
        td_cnt = 0;
        rand_tiles(1);
        send_all(0);
        wait_acc(NW, 30);
        compare_stream("fresh", 1);

        // ---------------- four tiles back to back, no gap ----------------
        do_reset();
        rand_tiles(4);
        wr_ready = 1'b1;
        send_all(0);
        for (int t = 1; t < 4; t++) begin
            for (int k = 0; k < NW - 1; k++) set_word(k, tdat[t][k]);
            valid_D = 9'h0FF;
            tick();
            valid_D = '0;
            b = 0;
            while (!(wr_en && wr_ready && acc_q.size() == NW * t - 1) && b < 40) begin
                tick();
                b++;
            end
            n_vec++;
            if (b >= 40) begin
                n_err++;
                $display("FAIL b2b_sync: got %0d accepts expected %0d", acc_q.size(), NW * t - 1);
            end
            set_word(NW - 1, tdat[t][NW - 1]);
            valid_D = 9'h100;
            tick();
            valid_D = '0;
        end
        wait_acc(4 * NW - 1, 40);
        chk("b2b_done_early", 32'(done), 0);
        wait_acc(4 * NW, 10);
        chk("b2b_done", 32'(done), 1);
        compare_stream("b2b", 4);
        for (int i = 1; i < 4 * NW; i++)
            if (i < acc_q.size())
                chk($sformatf("b2b_gap[%0d]", i), 32'(acc_q[i].cyc - acc_q[i-1].cyc), 1);
        if (acc_q.size() > 2 * NW) begin
            chk("b2b_tile1_base", 32'(acc_q[NW].addr), 3);
            chk("b2b_tile2_base", 32'(acc_q[2 * NW].addr), 18);
        end
        tick();
        chk("b2b_tile_done_cnt", 32'(td_cnt), 4);
        chk("b2b_no_ovf", 32'(overflow), 0);
        valid_D = 9'h010;
        tick();
        valid_D = '0;
        tick();
        tick();
        chk("post_done_ovf", 32'(overflow), 1);
        chk("post_done_wr_en", 32'(wr_en), 0);
        chk("post_done_writes", 32'(acc_q.size()), 36);
        chk("post_done_sticky", 32'(done), 1);

        // ---------------- randomized tiles against the model ----------------
        for (int it = 0; it < 3; it++) begin
            do_reset();
            rand_tiles(4);
            rnd_rdy = 1'b1;
            for (int t = 0; t < 4; t++) begin
                if (t >= 2) begin
                    b = 0;
                    while (acc_q.size() < NW * (t - 1) && b < 400) begin
                        tick();
                        b++;
                    end
                end
                rem = '1;
                while (rem != '0) begin
                    sel = rem & NW'($urandom);
                    for (int k = 0; k < NW; k++) if (sel[k]) set_word(k, tdat[t][k]);
                    valid_D = sel;
                    tick();
                    valid_D = '0;
                    rem = rem & ~sel;
                end
            end
            wait_acc(4 * NW, 1000);
            rnd_rdy = 1'b0;
            wr_ready = 1'b1;
            tick();
            tick();
            compare_stream($sformatf("rnd%0d", it), 4);
            chk($sformatf("rnd%0d_count", it), 32'(acc_q.size()), 36);
            chk($sformatf("rnd%0d_done", it), 32'(done), 1);
            chk($sformatf("rnd%0d_ovf", it), 32'(overflow), 0);
            chk($sformatf("rnd%0d_tile_done", it), 32'(td_cnt), 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
